// File: rtl/sdm_mash3_cfg_if.sv
// Control/data bundle between a stimulus source (master) and the
// configurable-order MASH 1-1-1 modulator (slave).
interface sdm_mash3_cfg_if #(
  parameter int W = 16
);
  logic         en;
  logic [W-1:0] din;
  logic         din_ld;
  logic [1:0]   order;
  logic         dither_en;
  logic [3:0]   sdm_out;
  logic         sdm_qn;
  logic         out_vld;

  modport master (
    output en, din, din_ld, order, dither_en,
    input  sdm_out, sdm_qn, out_vld
  );

  modport slave (
    input  en, din, din_ld, order, dither_en,
    output sdm_out, sdm_qn, out_vld
  );
endinterface

// File: rtl/sdm_mash3_cfg.sv
// Configurable-order (1..3) MASH 1-1-1 sigma-delta modulator.
// An unsigned W-bit fraction becomes a signed 4-bit multi-level stream
// whose mean is din/2^W. An order change flushes the cascade, and
// out_vld stays low until the differentiator start-up transient has
// passed. Optional LFSR dither enters as the stage-1 carry-in.
module sdm_mash3_cfg #(
  parameter int          W         = 16,
  parameter logic [14:0] LFSR_SEED = 15'h0001
) (
  input  logic              clk,
  input  logic              rstn,
  sdm_mash3_cfg_if.slave    bus
);

  typedef enum logic [1:0] {
    PH_OFF    = 2'd0,
    PH_FLUSH  = 2'd1,
    PH_SETTLE = 2'd2,
    PH_RUN    = 2'd3
  } phase_e;

  logic [W-1:0] frac_q, frac_d;
  logic [W-1:0] acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic         c2_z1_q, c2_z1_d, c3_z1_q, c3_z1_d, c3_z2_q, c3_z2_d;
  logic [1:0]   order_q, order_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [14:0]  lfsr_q, lfsr_d;
  logic [3:0]   sdm_out_q, sdm_out_d;
  logic         sdm_qn_q, sdm_qn_d;
  logic         out_vld_q, out_vld_d;

  logic         dith_s;
  logic [W:0]   s1_s, s2_s, s3_s;
  logic         c1_s, c2_s, c3_s;
  logic [4:0]   y_s;
  phase_e       phase_s;

  // Accumulator cascade and the order-dependent noise-shaped output.
  // y is formed modulo 32; its range (-3..+4) fits the 4-bit output.
  always_comb begin
    dith_s = lfsr_q[0] & bus.dither_en;
    s1_s   = {1'b0, acc1_q} + {1'b0, frac_q} + {{W{1'b0}}, dith_s};
    s2_s   = {1'b0, acc2_q} + {1'b0, s1_s[W-1:0]};
    s3_s   = {1'b0, acc3_q} + {1'b0, s2_s[W-1:0]};
    c1_s   = s1_s[W];
    c2_s   = s2_s[W];
    c3_s   = s3_s[W];
    case (order_q)
      2'd1: y_s = {4'd0, c1_s};
      2'd2: y_s = {4'd0, c1_s} + {4'd0, c2_s} - {4'd0, c2_z1_q};
      2'd3: y_s = {4'd0, c1_s} + {4'd0, c2_s} - {4'd0, c2_z1_q}
                + {4'd0, c3_s} - {3'd0, c3_z1_q, 1'b0} + {4'd0, c3_z2_q};
      default: y_s = 5'd0;
    endcase
  end

  // Phase decode: a pending order change always wins and flushes.
  always_comb begin
    if (bus.order != order_q) begin
      phase_s = PH_FLUSH;
    end else if (order_q == 2'd0) begin
      phase_s = PH_OFF;
    end else if (cnt_q != 2'd0) begin
      phase_s = PH_SETTLE;
    end else begin
      phase_s = PH_RUN;
    end
  end

  // Next-state for one enabled edge; the LFSR and fraction load run in
  // every phase, flush included.
  always_comb begin
    frac_d    = bus.din_ld ? bus.din : frac_q;
    lfsr_d    = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    order_d   = order_q;
    cnt_d     = cnt_q;
    acc1_d    = {W{1'b0}};
    acc2_d    = {W{1'b0}};
    acc3_d    = {W{1'b0}};
    c2_z1_d   = 1'b0;
    c3_z1_d   = 1'b0;
    c3_z2_d   = 1'b0;
    sdm_out_d = 4'd0;
    sdm_qn_d  = 1'b1;
    out_vld_d = 1'b0;
    case (phase_s)
      PH_FLUSH: begin
        order_d = bus.order;
        cnt_d   = bus.order;
      end
      PH_OFF: begin
        cnt_d = 2'd0;
      end
      PH_SETTLE, PH_RUN: begin
        acc1_d  = s1_s[W-1:0];
        acc2_d  = s2_s[W-1:0];
        acc3_d  = s3_s[W-1:0];
        c2_z1_d = c2_s;
        c3_z1_d = c3_s;
        c3_z2_d = c3_z1_q;
        if (phase_s == PH_SETTLE) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
        if ((phase_s == PH_RUN) || (cnt_q == 2'd1)) begin
          sdm_out_d = y_s[3:0];
          sdm_qn_d  = ~c1_s;
          out_vld_d = 1'b1;
        end else begin
          sdm_out_d = 4'd0;
          sdm_qn_d  = 1'b1;
          out_vld_d = 1'b0;
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  // State register: asynchronous reset (asserted high), advance only on en.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      frac_q    <= {W{1'b0}};
      acc1_q    <= {W{1'b0}};
      acc2_q    <= {W{1'b0}};
      acc3_q    <= {W{1'b0}};
      c2_z1_q   <= 1'b0;
      c3_z1_q   <= 1'b0;
      c3_z2_q   <= 1'b0;
      order_q   <= 2'd0;
      cnt_q     <= 2'd0;
      lfsr_q    <= LFSR_SEED;
      sdm_out_q <= 4'd0;
      sdm_qn_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else if (bus.en) begin
      frac_q    <= frac_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      c2_z1_q   <= c2_z1_d;
      c3_z1_q   <= c3_z1_d;
      c3_z2_q   <= c3_z2_d;
      order_q   <= order_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      sdm_out_q <= sdm_out_d;
      sdm_qn_q  <= sdm_qn_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.sdm_out = sdm_out_q;
  assign bus.sdm_qn  = sdm_qn_q;
  assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_sdm_mash3_cfg.sv
// Self-checking bench for sdm_mash3_cfg: directed scenarios plus a
// randomized phase, each edge compared against a behavioural model that
// works on plain integers (fractions, carries as threshold crossings).
module tb_sdm_mash3_cfg;
  localparam int W   = 16;
  localparam int MOD = 1 << W;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  sdm_mash3_cfg_if #(.W(W)) bus_if ();

  sdm_mash3_cfg #(.W(W), .LFSR_SEED(15'h0001)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (integers)
  int m_frac, m_a1, m_a2, m_a3;
  int m_c2p, m_c3p, m_c3pp;
  int m_ord, m_cnt, m_lfsr;
  int m_out, m_vld, m_qn;

  task automatic m_reset();
    m_frac = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
    m_c2p = 0; m_c3p = 0; m_c3pp = 0;
    m_ord = 0; m_cnt = 0; m_lfsr = 1;
    m_out = 0; m_vld = 0; m_qn = 1;
  endtask

  task automatic m_clear();
    m_a1 = 0; m_a2 = 0; m_a3 = 0;
    m_c2p = 0; m_c3p = 0; m_c3pp = 0;
    m_out = 0; m_vld = 0; m_qn = 1;
  endtask

  // One enabled clock edge of the modulator, from the behavioural rules.
  task automatic m_edge();
    int d, t, c1, c2, c3, y, nf;
    if (bus_if.en !== 1'b1) return;
    d  = (bus_if.dither_en === 1'b1) ? (m_lfsr % 2) : 0;
    nf = (bus_if.din_ld === 1'b1) ? int'(bus_if.din) : m_frac;
    if (int'(bus_if.order) != m_ord) begin
      m_ord = int'(bus_if.order);
      m_cnt = m_ord;
      m_clear();
    end else if (m_ord == 0) begin
      m_clear();
    end else begin
      t = m_a1 + m_frac + d; c1 = (t >= MOD) ? 1 : 0; m_a1 = t % MOD;
      t = m_a2 + m_a1;       c2 = (t >= MOD) ? 1 : 0; m_a2 = t % MOD;
      t = m_a3 + m_a2;       c3 = (t >= MOD) ? 1 : 0; m_a3 = t % MOD;
      if (m_ord == 1)      y = c1;
      else if (m_ord == 2) y = c1 + (c2 - m_c2p);
      else                 y = c1 + (c2 - m_c2p) + (c3 - 2 * m_c3p + m_c3pp);
      m_c2p = c2; m_c3pp = m_c3p; m_c3p = c3;
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_out = y; m_vld = 1; m_qn = 1 - c1;
      end else begin
        m_out = 0; m_vld = 0; m_qn = 1;
      end
    end
    m_frac = nf;
    m_lfsr = ((m_lfsr * 2) + (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) % 32768;
  endtask

  function automatic int dut_out();
    logic signed [3:0] v;
    v = bus_if.sdm_out;
    return int'(v);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out"}, dut_out(), m_out);
    chk({tag, ".vld"}, int'(bus_if.out_vld), m_vld);
    chk({tag, ".qn"},  int'(bus_if.sdm_qn), m_qn);
  endtask

  // Advance one clock, update the model, sample 1 time unit later.
  task automatic cyc(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    chk_model(tag);
  endtask

  initial begin
    int sum, bad, v;
    logic [15:0] rdin;
    checks = 0;
    errors = 0;
    m_reset();
    rstn = 1'b1;
    bus_if.en = 1'b0; bus_if.din = 16'd0; bus_if.din_ld = 1'b0;
    bus_if.order = 2'd0; bus_if.dither_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_model("reset");
    chk("reset.qn_const", int'(bus_if.sdm_qn), 1);

    // Order 1, half-scale fraction loaded with the flush edge
    rstn = 1'b0;
    bus_if.en = 1'b1; bus_if.order = 2'd1;
    bus_if.din = 16'd32768; bus_if.din_ld = 1'b1;
    cyc("o1.flush");
    chk("o1.flush.vld", int'(bus_if.out_vld), 0);
    bus_if.din_ld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc("o1.run");
      chk("o1.vld_const", int'(bus_if.out_vld), 1);
      chk("o1.out_const", dut_out(), i % 2);
      chk("o1.qn_const", int'(bus_if.sdm_qn), 1 - (i % 2));
    end

    // Order 3 with zero fraction: silent after three settle edges
    bus_if.order = 2'd3; bus_if.din = 16'd0; bus_if.din_ld = 1'b1;
    cyc("o3z.flush");
    bus_if.din_ld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc("o3z");
      chk("o3z.vld_const", int'(bus_if.out_vld), (i >= 3) ? 1 : 0);
      chk("o3z.out_const", dut_out(), 0);
    end

    // Order 3, din=39425: range and long-run mean over 65536 samples
    bus_if.din = 16'd39425; bus_if.din_ld = 1'b1;
    cyc("o3.load");
    bus_if.din_ld = 1'b0;
    cyc("o3.pre");
    sum = 0; bad = 0;
    for (int i = 0; i < 65536; i++) begin
      cyc("o3.long");
      v = dut_out();
      sum += v;
      if (v < -3 || v > 4 || bus_if.out_vld !== 1'b1) bad++;
    end
    chk("o3.range_viol", bad, 0);
    chk("o3.sum_ok", ((sum >= 39425 - 3) && (sum <= 39425 + 3)) ? 1 : 0, 1);

    // Switch order 3 -> 1: flush, valid one edge later, binary output
    bus_if.order = 2'd1;
    cyc("sw.flush");
    chk("sw.flush.vld", int'(bus_if.out_vld), 0);
    for (int i = 0; i < 10; i++) begin
      cyc("sw.run");
      chk("sw.vld_const", int'(bus_if.out_vld), 1);
      chk("sw.binary", (dut_out() == 0 || dut_out() == 1) ? 1 : 0, 1);
    end

    // Clock-enable low for five cycles mid-run (order 3, dithered)
    bus_if.order = 2'd3; bus_if.din = 16'd12345; bus_if.din_ld = 1'b1;
    bus_if.dither_en = 1'b1;
    cyc("en.flush");
    bus_if.din_ld = 1'b0;
    repeat (10) cyc("en.pre");
    bus_if.en = 1'b0;
    repeat (5) cyc("en.low");
    bus_if.en = 1'b1;
    repeat (20) cyc("en.post");

    // Asynchronous reset between edges, then order-2 dithered run
    @(posedge clk);
    m_edge();
    #3;
    rstn = 1'b1;
    #1;
    m_reset();
    chk_model("arst");
    chk("arst.vld_const", int'(bus_if.out_vld), 0);
    #2;
    rstn = 1'b0;
    bus_if.order = 2'd2; bus_if.din = 16'd0; bus_if.din_ld = 1'b1;
    bus_if.dither_en = 1'b1;
    cyc("o2.flush");
    bus_if.din_ld = 1'b0;
    cyc("o2.e1");
    chk("o2.e1.vld", int'(bus_if.out_vld), 0);
    cyc("o2.e2");
    chk("o2.e2.vld", int'(bus_if.out_vld), 1);
    repeat (2000) cyc("o2.dith");

    // Randomized mix of enables, loads, order changes and dither
    for (int i = 0; i < 4000; i++) begin
      bus_if.en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
      bus_if.din_ld = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      rdin = 16'($urandom);
      bus_if.din = rdin;
      if ($urandom_range(0, 49) == 0) bus_if.order = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus_if.dither_en = ~bus_if.dither_en;
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
